// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: instruction width, fetch FSM state encoding, branch-select
// codes and the branch condition helper used by branch_unit.
package fetch_pkg;

  localparam int INST_W = 16;
  localparam int OFF_W  = 6;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } state_e;

  localparam logic [2:0] BS_BZ   = 3'b000;
  localparam logic [2:0] BS_BNZ  = 3'b001;
  localparam logic [2:0] BS_BN   = 3'b010;
  localparam logic [2:0] BS_BNN  = 3'b011;
  localparam logic [2:0] BS_NONE = 3'b100;

  // Branch condition evaluation; unused select codes are never taken.
  function automatic logic branch_taken(input logic [2:0] bs,
                                        input logic       zero,
                                        input logic       neg);
    logic t;
    t = 1'b0;
    case (bs)
      BS_BZ:   t = zero;
      BS_BNZ:  t = ~zero;
      BS_BN:   t = neg;
      BS_BNN:  t = ~neg;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/branch_unit.sv
// Next-PC resolution: decides taken from bs/zero/neg and forms the target.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
//
// Ports:
//   pc       in   PC_W  address of the instruction being retired
//   bs       in   3     branch select
//   off      in   6     signed branch offset, relative to pc+1
//   zero/neg in   1     ALU condition flags
//   taken    out  1     branch condition holds
//   next_pc  out  PC_W  pc+1+sext(off) when taken, else pc+1 (mod 2^PC_W)
module branch_unit
  import fetch_pkg::*;
#(
  parameter int PC_W = 16
) (
  input  logic [PC_W-1:0]  pc,
  input  logic [2:0]       bs,
  input  logic [OFF_W-1:0] off,
  input  logic             zero,
  input  logic             neg,
  output logic             taken,
  output logic [PC_W-1:0]  next_pc
);

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] off_sext;

  assign pc_inc   = pc + PC_W'(1);
  assign off_sext = {{(PC_W-OFF_W){off[OFF_W-1]}}, off};
  assign taken    = branch_taken(bs, zero, neg);

  // Natural truncation to PC_W bits gives the required wrap-around.
  assign next_pc  = taken ? (pc_inc + off_sext) : pc_inc;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, reads imem over req/ack, issues words to the decoder.
// Latency: req one cycle after reset release; ack-to-inst_valid one cycle; best case 1 instr / 2 cycles.
// Backpressure: imem wait states stretch FETCH, inst_ready low stretches ISSUE, both unbounded.
//
// Ports:
//   clk, rst               clock (rising edge), async active-high reset
//   imem_req/addr          read request, word address (always equals pc)
//   imem_ack/rdata         read data strobe and instruction word
//   inst/inst_valid        registered instruction and its valid flag
//   inst_ready             decoder accepts inst this cycle
//   pc                     address of the word on inst
//   bs/off/halt            decoder branch select, offset, halt for inst
//   zero/neg               ALU flags for inst
//   halted                 processor stopped (only rst leaves)
//   perf_issued/perf_taken saturating event counters, present only with FETCH_PERF_EN
//
// Optional feature macro: FETCH_PERF_EN.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [PC_W-1:0]   pc,
  input  logic [2:0]        bs,
  input  logic [OFF_W-1:0]  off,
  input  logic              halt,
  input  logic              zero,
  input  logic              neg,
  output logic              halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]       perf_issued,
  output logic [15:0]       perf_taken
`endif
);

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic [PC_W-1:0]     br_next_pc;
  logic                issue_hs;

`ifdef FETCH_PERF_EN
  logic                br_taken;
`endif

  branch_unit #(
    .PC_W (PC_W)
  ) u_branch (
    .pc      (pc_q),
    .bs      (bs),
    .off     (off),
    .zero    (zero),
    .neg     (neg),
`ifdef FETCH_PERF_EN
    .taken   (br_taken),
`else
    .taken   (),
`endif
    .next_pc (br_next_pc)
  );

  assign issue_hs = (state_q == ISSUE) && inst_ready;

  // State register. Reset abandons any outstanding request; a late ack
  // lands in BOOT and is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    case (state_q)
      BOOT: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          inst_d  = imem_rdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (inst_ready) begin
          // Halt takes priority over any branch: pc stays on the halting word.
          if (halt) begin
            state_d = HALT;
          end else begin
            pc_d    = br_next_pc;
            state_d = FETCH;
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // All handshake outputs are pure decodes of the state register.
  assign imem_req   = (state_q == FETCH);
  assign imem_addr  = pc_q;
  assign inst       = inst_q;
  assign inst_valid = (state_q == ISSUE);
  assign pc         = pc_q;
  assign halted     = (state_q == HALT);

`ifdef FETCH_PERF_EN
  logic [15:0] perf_issued_q;
  logic [15:0] perf_taken_q;

  // The halting handshake counts as issued but never as a taken branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issued_q <= '0;
      perf_taken_q  <= '0;
    end else begin
      if (issue_hs && (perf_issued_q != 16'hFFFF)) begin
        perf_issued_q <= perf_issued_q + 16'd1;
      end
      if (issue_hs && !halt && br_taken && (perf_taken_q != 16'hFFFF)) begin
        perf_taken_q <= perf_taken_q + 16'd1;
      end
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_taken  = perf_taken_q;
`else
  logic unused_hs;
  assign unused_hs = issue_hs;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: memory model feeds a scoreboard of
// {addr, word} pairs that are compared at each issue handshake; a table of
// branch vectors plus hand sequences for stalls, halt and reset mid-fetch.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  wire         imem_req;
  wire  [15:0] imem_addr;
  wire         imem_ack;
  logic [15:0] imem_rdata;
  wire  [15:0] inst;
  wire         inst_valid;
  logic        inst_ready;
  wire  [15:0] pc;
  logic [2:0]  bs;
  logic [5:0]  off;
  logic        halt;
  logic        zero;
  logic        neg;
  wire         halted;

  // Memory model controls
  logic        mem_en;
  int          mem_delay;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        force_ack;
  logic [15:0] force_rdata;

  assign imem_ack   = mem_en ? mem_ack : force_ack;
  assign imem_rdata = mem_en ? mem_rdata : force_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } fetch_t;
  fetch_t sb[$];

  typedef struct {
    string       nm;
    logic [5:0]  setup;   // offset of a BZ-taken branch at pc 0 to reach the test pc
    logic [2:0]  b;
    logic [5:0]  o;
    logic        z;
    logic        n;
    logic [15:0] exp_next;
  } vec_t;
  vec_t vecs[9];

  instr_fetch #(
    .PC_W     (16),
    .RESET_PC (16'h0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst       (inst),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .pc         (pc),
    .bs         (bs),
    .off        (off),
    .halt       (halt),
    .zero       (zero),
    .neg        (neg),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] word_at(input logic [15:0] a);
    if (a == 16'h0000) return 16'h2042;
    if (a == 16'h0001) return 16'h5081;
    return {a[7:0] ^ 8'hA5, a[7:0]};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Memory: answers a request after mem_delay waiting cycles, recording
  // what it returned so the issue side can check it.
  initial begin
    int wait_cnt;
    fetch_t e;
    mem_ack = 1'b0;
    mem_rdata = '0;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (imem_req && !rst && mem_en) begin
        if (wait_cnt >= mem_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = word_at(imem_addr);
          e.addr = imem_addr;
          e.data = mem_rdata;
          sb.push_back(e);
          wait_cnt = 0;
        end else begin
          mem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_ack = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    inst_ready = 1'b0;
    @(negedge clk);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait for inst_valid, optionally stall, then hand-shake one instruction.
  task automatic issue(input string nm, input logic [2:0] b, input logic [5:0] o,
                       input logic h, input logic z, input logic n,
                       input int stall, output int t_valid);
    logic [15:0] pc0, inst0;
    fetch_t e;
    int w;
    t_valid = 0;
    @(negedge clk);
    w = 0;
    while (!inst_valid && w < 200) begin
      if (imem_req) check({nm, " addr_eq_pc"}, imem_addr, pc);
      @(negedge clk);
      w++;
    end
    if (!inst_valid) begin
      check({nm, " valid_timeout"}, 0, 1);
      return;
    end
    t_valid = cyc;
    pc0 = pc;
    inst0 = inst;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({nm, " stall_valid"}, inst_valid, 1);
      check({nm, " stall_pc"}, pc, pc0);
      check({nm, " stall_inst"}, inst, inst0);
    end
    bs = b; off = o; halt = h; zero = z; neg = n;
    inst_ready = 1'b1;
    if (sb.size() == 0) begin
      check({nm, " sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check({nm, " pc"}, pc, e.addr);
      check({nm, " inst"}, inst, e.data);
    end
    @(posedge clk);
    #1;
    inst_ready = 1'b0;
    check({nm, " valid_drop"}, inst_valid, 0);
  endtask

  initial begin
    int t1, t2, td;
    rst = 1'b1;
    inst_ready = 1'b0;
    bs = 3'b100; off = '0; halt = 1'b0; zero = 1'b0; neg = 1'b0;
    mem_en = 1'b1; mem_delay = 0;
    force_ack = 1'b0; force_rdata = '0;

    vecs[0] = '{"bz_taken",    6'd15,  3'b000, 6'h3E, 1'b1, 1'b0, 16'h000F};
    vecs[1] = '{"bz_not",      6'd15,  3'b000, 6'h3E, 1'b0, 1'b0, 16'h0011};
    vecs[2] = '{"bnone",       6'd15,  3'b100, 6'h3E, 1'b1, 1'b1, 16'h0011};
    vecs[3] = '{"wrap_ffff",   6'h3E,  3'b100, 6'h05, 1'b1, 1'b0, 16'h0000};
    vecs[4] = '{"wrap_bnn",    6'h3D,  3'b011, 6'h1F, 1'b0, 1'b0, 16'h001E};
    vecs[5] = '{"bn_min_off",  6'd15,  3'b010, 6'h20, 1'b0, 1'b1, 16'hFFF1};
    vecs[6] = '{"bnz_taken",   6'd15,  3'b001, 6'h05, 1'b0, 1'b0, 16'h0016};
    vecs[7] = '{"bs111",       6'd15,  3'b111, 6'h05, 1'b1, 1'b1, 16'h0011};
    vecs[8] = '{"bnn_not",     6'd15,  3'b011, 6'h05, 1'b0, 1'b1, 16'h0011};

    // Reset values while rst is held
    repeat (2) @(negedge clk);
    check("rst imem_req", imem_req, 0);
    check("rst imem_addr", imem_addr, 16'h0000);
    check("rst pc", pc, 16'h0000);
    check("rst inst", inst, 16'h0000);
    check("rst inst_valid", inst_valid, 0);
    check("rst halted", halted, 0);

    // Release: req rises one cycle later; back-to-back issue every 2 cycles
    rst = 1'b0;
    #1;
    check("boot imem_req", imem_req, 0);
    @(negedge clk);
    check("req_rise", imem_req, 1);
    issue("first", 3'b100, 6'h00, 1'b0, 1'b0, 1'b0, 0, t1);
    issue("second", 3'b100, 6'h00, 1'b0, 1'b0, 1'b0, 0, t2);
    td = t2 - t1;
    check("throughput_cycles", td, 2);

    // Memory wait states and downstream stall
    mem_delay = 3;
    issue("stall", 3'b100, 6'h00, 1'b0, 1'b0, 1'b0, 4, t1);
    issue("after_stall", 3'b100, 6'h00, 1'b0, 1'b0, 1'b0, 0, t2);
    check("after_stall next_pc", pc, 16'h0004);
    mem_delay = 0;

    // Branch resolution table
    foreach (vecs[i]) begin
      do_reset();
      issue({vecs[i].nm, " setup"}, 3'b000, vecs[i].setup, 1'b0, 1'b1, 1'b0, 0, t1);
      issue(vecs[i].nm, vecs[i].b, vecs[i].o, 1'b0, vecs[i].z, vecs[i].n, 0, t1);
      check({vecs[i].nm, " next_pc"}, pc, vecs[i].exp_next);
      check({vecs[i].nm, " next_addr"}, imem_addr, vecs[i].exp_next);
      check({vecs[i].nm, " next_req"}, imem_req, 1);
    end

    // Halt beats a taken branch, then only reset leaves
    do_reset();
    issue("halt setup", 3'b000, 6'd31, 1'b0, 1'b1, 1'b0, 0, t1);
    issue("halt", 3'b000, 6'h05, 1'b1, 1'b1, 1'b0, 0, t1);
    mem_en = 1'b0;
    force_ack = 1'b1;
    force_rdata = 16'hFFFF;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("halt halted", halted, 1);
      check("halt pc", pc, 16'h0020);
      check("halt imem_req", imem_req, 0);
      check("halt inst_valid", inst_valid, 0);
    end
    force_ack = 1'b0;
    mem_en = 1'b1;
    do_reset();
    check("unhalt halted", halted, 0);
    check("unhalt pc", pc, 16'h0000);
    issue("restart", 3'b100, 6'h00, 1'b0, 1'b0, 1'b0, 0, t1);

    // Reset pulse while FETCH waits, with an ack in the reset cycle
    do_reset();
    issue("midrst setup", 3'b000, 6'd15, 1'b0, 1'b1, 1'b0, 0, t1);
    mem_en = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst waiting_req", imem_req, 1);
    check("midrst waiting_addr", imem_addr, 16'h0010);
    force_ack = 1'b1;
    force_rdata = 16'hBEEF;
    rst = 1'b1;
    #1;
    check("midrst imem_req", imem_req, 0);
    check("midrst imem_addr", imem_addr, 16'h0000);
    check("midrst pc", pc, 16'h0000);
    check("midrst inst", inst, 16'h0000);
    check("midrst inst_valid", inst_valid, 0);
    check("midrst halted", halted, 0);
    @(negedge clk);
    check("midrst ack_ignored", inst, 16'h0000);
    force_ack = 1'b0;
    sb.delete();
    mem_en = 1'b1;
    rst = 1'b0;
    issue("midrst restart", 3'b100, 6'h00, 1'b0, 1'b0, 1'b0, 0, t1);
    check("midrst restart next", pc, 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit for the 16-bit processor. It owns the program counter and reads 16-bit instruction words from instruction memory over a req/ack handshake. It presents each word to the instruction decoder over a valid/ready handshake. When an instruction is accepted, it resolves the next PC from the decoder's branch-select, offset and halt outputs together with the ALU condition flags.

## Interface
Parameters:
- PC_W, 16, PC and instruction-memory word-address width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous assertion, active-high.
- imem_req  out  1  instruction-memory read request.
- imem_addr  out  PC_W  word address; always equals pc.
- imem_ack  in  1  read data valid on this cycle.
- imem_rdata  in  16  instruction word.
- inst  out  16  registered instruction word, drives the decoder INST input.
- inst_valid  out  1  inst holds a fetched word.
- inst_ready  in  1  downstream accepts inst this cycle.
- pc  out  PC_W  address of the word currently on inst.
- bs  in  3  decoder branch select for the presented inst.
- off  in  6  decoder branch offset, two's complement.
- halt  in  1  decoder halt for the presented inst.
- zero  in  1  ALU zero flag for the presented inst.
- neg  in  1  ALU result sign flag for the presented inst.
- halted  out  1  processor is stopped.

## Operation
- FSM states: BOOT, FETCH, ISSUE, HALT.
- BOOT: reset state. On the first clk edge after rst deasserts, go to FETCH.
- FETCH:
  - imem_req=1 and imem_addr=pc, held stable until ack.
  - On a cycle with imem_ack=1: inst<=imem_rdata, inst_valid<=1, go to ISSUE.
- ISSUE:
  - inst_valid=1; inst and pc are held stable until inst_ready=1. inst_valid is never retracted.
  - Handshake is inst_valid & inst_ready. On the handshake edge, bs/off/halt/zero/neg are sampled combinationally in that same cycle, then:
  - halt=1: halted<=1, pc unchanged, inst_valid<=0, go to HALT. Halt wins over any branch.
  - Otherwise: pc<=next_pc, inst_valid<=0, go to FETCH.
- Branch taken:
  - bs=000: taken when zero=1.
  - bs=001: taken when zero=0.
  - bs=010: taken when neg=1.
  - bs=011: taken when neg=0.
  - bs=100: never taken.
  - bs=101..111: not taken.
- next_pc:
  - Taken: pc+1+sext(off), range −32..+31 relative to pc+1.
  - Not taken: pc+1.
  - Arithmetic is modulo 2^PC_W; 2^PC_W−1 wraps to 0.
- HALT: terminal. imem_req=0, inst_valid=0, halted=1. Only rst exits.
- imem_ack outside FETCH is ignored. imem_rdata is sampled only on the ack cycle.

## Timing
- Reset values: imem_req=0, imem_addr=pc=RESET_PC, inst=16'h0000, inst_valid=0, halted=0, state=BOOT.
- rst asserted mid-operation: all of the above take effect immediately (asynchronous), any outstanding request is abandoned, and a late ack is ignored.
- imem_req is a decode of the state register; it rises one cycle after rst release.
- Minimum latency:
  - ack in the same cycle as req gives inst_valid on the next cycle.
  - Best-case throughput is one instruction per 2 cycles.
- Memory wait states and downstream stalls extend FETCH and ISSUE respectively with no limit.
- pc changes only on the handshake edge or on reset.

## Configuration
- FETCH_PERF_EN defined:
  - Adds outputs perf_issued[15:0] (count of accepted handshakes, including the halting one) and perf_taken[15:0] (count of taken branches).
  - Both counters saturate at 16'hFFFF and reset to 0.
- FETCH_PERF_EN undefined: ports and counters are absent; all other behaviour is identical.

## Structure
- Package fetch_pkg holds:
  - INST_W=16.
  - State enum: BOOT, FETCH, ISSUE, HALT.
  - BS constants: BS_BZ=3'b000, BS_BNZ=3'b001, BS_BN=3'b010, BS_BNN=3'b011, BS_NONE=3'b100.
- Sub-module branch_unit: combinational; inputs pc, bs, off, zero, neg; outputs taken and next_pc.
- instr_fetch instantiates branch_unit and contains the FSM, the registers and the optional counters.

## Test plan
- Reset release, memory always acks, inst_ready=1, words 0x2042 at 0 and 0x5081 at 1 → req rises 1 cycle after release; inst=0x2042 with pc=0, then inst=0x5081 with pc=1; one instruction per 2 cycles.
- Ack delayed 3 cycles and inst_ready held low 4 cycles → imem_addr, inst and pc stable throughout; no duplicate or dropped issue.
- At pc=0x0010: bs=000, zero=1, off=6'h3E (−2) → next fetch at 0x000F. Same with zero=0 → 0x0011. bs=100 with zero=1 → 0x0011.
- PC_W=16, pc=0xFFFF, bs=100 → next fetch at 0x0000. pc=0xFFFE, bs=011, neg=0, off=6'h1F → next fetch at 0x001E.
- halt=1 with bs=000 and zero=1 at pc=0x0020 → halted=1, pc stays 0x0020, imem_req=0 forever, later acks ignored; rst then restarts at RESET_PC.
- rst pulsed while in FETCH awaiting ack, ack arriving in the rst cycle → all outputs at reset values immediately, the ack is not captured, and fetch restarts at RESET_PC.
